// File: rtl/alu_seq_ctrl_311_if.sv
// Handshake and ALU-side bundle for the operand sequencer: nibble input stream,
// registered ALU operands, ALU result return and the valid/ready result port.
interface alu_seq_ctrl_311_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned RW = 8
);
    logic [DW-1:0] InData_311;
    logic          InValid_311;
    logic          InReady_311;
    logic [DW-1:0] AluIn1_311;
    logic [DW-1:0] AluIn2_311;
    logic [DW-1:0] AluSel_311;
    logic [RW-1:0] AluOut_311;
    logic [RW-1:0] Res_311;
    logic          ResValid_311;
    logic          ResReady_311;
    logic          Err_311;
    logic          Busy_311;

    // Sequencer side
    modport slave (
        input  InData_311, InValid_311, AluOut_311, ResReady_311,
        output InReady_311, AluIn1_311, AluIn2_311, AluSel_311,
               Res_311, ResValid_311, Err_311, Busy_311
    );

    // Environment side: stream source, ALU and result sink
    modport master (
        output InData_311, InValid_311, AluOut_311, ResReady_311,
        input  InReady_311, AluIn1_311, AluIn2_311, AluSel_311,
               Res_311, ResValid_311, Err_311, Busy_311
    );
endinterface

// File: rtl/alu_seq_ctrl_311.sv
// Operand sequencer in front of the 4-bit ALU: gathers In1/In2/Sel nibbles, runs one
// settle cycle, then offers the 8-bit result. Optional macro: ALU_DIVZERO_CHK_EN.
module alu_seq_ctrl_311 #(
    parameter int unsigned DW = 4,
    parameter int unsigned RW = 8
) (
    input  logic              Clk_311,
    input  logic              Rst_311,
    alu_seq_ctrl_311_if.slave bus
);
    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_B   = 3'd1,
        S_OP  = 3'd2,
        S_EX  = 3'd3,
        S_OUT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] in1_q, in1_d;
    logic [DW-1:0] in2_q, in2_d;
    logic [DW-1:0] sel_q, sel_d;
    logic [RW-1:0] res_q, res_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic          in_ready;
    logic          in_fire;
    logic          out_fire;

    // Ready is a pure state decode so the source never sees a valid->ready loop
    assign in_ready = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);
    assign in_fire  = bus.InValid_311 && in_ready;
    assign out_fire = res_valid_q && bus.ResReady_311;

    always_ff @(posedge Clk_311) begin
        if (Rst_311) begin
            state_q     <= S_A;
            in1_q       <= '0;
            in2_q       <= '0;
            sel_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            sel_q       <= sel_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        sel_d       = sel_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;

        unique case (state_q)
            S_A: begin
                if (in_fire) begin
                    in1_d   = bus.InData_311;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (in_fire) begin
                    in2_d   = bus.InData_311;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (in_fire) begin
                    sel_d   = bus.InData_311;
                    state_d = S_EX;
                end
            end
            S_EX: begin
                // Operands have been stable for a full cycle; sample the ALU now
`ifdef ALU_DIVZERO_CHK_EN
                if (((sel_q == DW'(3)) || (sel_q == DW'(4))) && (in2_q == '0)) begin
                    res_d = RW'(8'hFF);
                    err_d = 1'b1;
                end else begin
                    res_d = bus.AluOut_311;
                    err_d = 1'b0;
                end
`else
                res_d = bus.AluOut_311;
                err_d = 1'b0;
`endif
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_fire) begin
                    res_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    assign bus.InReady_311  = in_ready;
    assign bus.Busy_311     = (state_q != S_A);
    assign bus.AluIn1_311   = in1_q;
    assign bus.AluIn2_311   = in2_q;
    assign bus.AluSel_311   = sel_q;
    assign bus.Res_311      = res_q;
    assign bus.ResValid_311 = res_valid_q;
    assign bus.Err_311      = err_q;
endmodule

// File: tb/tb_alu_seq_ctrl_311.sv
// Directed bench for alu_seq_ctrl_311 with a behavioural ALU and a result scoreboard.
module tb_alu_seq_ctrl_311;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] sb[$];

    alu_seq_ctrl_311_if #(.DW(4), .RW(8)) bus ();

    alu_seq_ctrl_311 #(.DW(4), .RW(8)) dut (
        .Clk_311 (clk),
        .Rst_311 (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in ALU; div/mod by zero gives 8'hEE so it differs from the checker value
    function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        logic [7:0] xa, xb;
        xa = {4'h0, a};
        xb = {4'h0, b};
        case (s)
            4'd0:    return xa + xb;
            4'd1:    return xa - xb;
            4'd2:    return xa * xb;
            4'd3:    return (b == 4'd0) ? 8'hEE : xa / xb;
            4'd4:    return (b == 4'd0) ? 8'hEE : xa % xb;
            4'd5:    return xa ^ xb;
            4'd6:    return xa << b;
            4'd7:    return xa >> b;
            4'd8:    return {4'h0, ~a};
            4'd9:    return xa | xb;
            4'd10:   return xa & xb;
            4'd11:   return {a, b};
            4'd12:   return xa;
            4'd13:   return xb;
            4'd14:   return {7'd0, a == b};
            default: return {7'd0, a > b};
        endcase
    endfunction

    always_comb bus.AluOut_311 = alu(bus.AluIn1_311, bus.AluIn2_311, bus.AluSel_311);

    // Expected {err, res} for one operation
    function automatic logic [8:0] expect_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
`ifdef ALU_DIVZERO_CHK_EN
        if (((s == 4'd3) || (s == 4'd4)) && (b == 4'd0))
            return {1'b1, 8'hFF};
`endif
        return {1'b0, alu(a, b, s)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        int n = 0;
        bus.InData_311  = d;
        bus.InValid_311 = 1'b1;
        while (bus.InReady_311 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_timeout", 32'(n >= 50), 32'd0);
        @(posedge clk);
        #1;
        bus.InValid_311 = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s, input bit gap);
        send(a);
        if (gap) begin @(posedge clk); #1; end
        send(b);
        if (gap) begin @(posedge clk); #1; end
        sb.push_back(expect_op(a, b, s));
        send(s);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (bus.ResValid_311 !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("res_valid_timeout", 32'(n >= 50), 32'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_res"}, 32'(bus.Res_311), 32'(e[7:0]));
            chk({tag, "_err"}, 32'(bus.Err_311), 32'(e[8]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.InData_311   = 4'h0;
        bus.InValid_311  = 1'b0;
        bus.ResReady_311 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(bus.ResValid_311), 32'd0);
        chk("rst_res", 32'(bus.Res_311), 32'd0);
        chk("rst_err", 32'(bus.Err_311), 32'd0);
        chk("rst_in1", 32'(bus.AluIn1_311), 32'd0);
        chk("rst_in2", 32'(bus.AluIn2_311), 32'd0);
        chk("rst_sel", 32'(bus.AluSel_311), 32'd0);
        chk("rst_in_ready", 32'(bus.InReady_311), 32'd1);
        chk("rst_busy", 32'(bus.Busy_311), 32'd0);
        rst = 1'b0;

        // Add with latency and handshake timing
        bus.ResReady_311 = 1'b1;
        send_op(4'd3, 4'd5, 4'd0, 1'b0);
        chk("add_ex_valid", 32'(bus.ResValid_311), 32'd0);
        chk("add_ex_in_ready", 32'(bus.InReady_311), 32'd0);
        chk("add_ex_busy", 32'(bus.Busy_311), 32'd1);
        @(posedge clk);
        #1;
        chk("add_out_valid", 32'(bus.ResValid_311), 32'd1);
        pop_check("add");
        @(posedge clk);
        #1;
        chk("add_done_valid", 32'(bus.ResValid_311), 32'd0);
        chk("add_done_in_ready", 32'(bus.InReady_311), 32'd1);
        chk("add_done_busy", 32'(bus.Busy_311), 32'd0);

        // Subtract with wrap
        send_op(4'd2, 4'd3, 4'd1, 1'b0);
        wait_valid();
        pop_check("sub");
        @(posedge clk);
        #1;

        // Multiply, then back-pressure while a nibble is offered
        bus.ResReady_311 = 1'b0;
        send_op(4'd15, 4'd15, 4'd2, 1'b0);
        wait_valid();
        pop_check("mul");
        bus.InData_311  = 4'd5;
        bus.InValid_311 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_res", 32'(bus.Res_311), 32'hE1);
        chk("hold_valid", 32'(bus.ResValid_311), 32'd1);
        chk("hold_in_ready", 32'(bus.InReady_311), 32'd0);
        chk("hold_busy", 32'(bus.Busy_311), 32'd1);
        chk("hold_in1", 32'(bus.AluIn1_311), 32'd15);
        bus.InValid_311  = 1'b0;
        bus.ResReady_311 = 1'b1;
        @(posedge clk);
        #1;
        chk("mul_done_valid", 32'(bus.ResValid_311), 32'd0);

        // Divide by zero, then reset while the result is held
        bus.ResReady_311 = 1'b0;
        send_op(4'd7, 4'd0, 4'd3, 1'b0);
        wait_valid();
        pop_check("divz");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("divz_rst_valid", 32'(bus.ResValid_311), 32'd0);
        chk("divz_rst_err", 32'(bus.Err_311), 32'd0);
        chk("divz_rst_busy", 32'(bus.Busy_311), 32'd0);

        // Reset mid-operation discards partial operands
        bus.ResReady_311 = 1'b1;
        send(4'd9);
        send(4'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.Busy_311), 32'd0);
        chk("midrst_in_ready", 32'(bus.InReady_311), 32'd1);
        chk("midrst_in1", 32'(bus.AluIn1_311), 32'd0);
        send_op(4'd6, 4'd2, 4'd10, 1'b0);
        chk("midrst_op_in1", 32'(bus.AluIn1_311), 32'd6);
        chk("midrst_op_in2", 32'(bus.AluIn2_311), 32'd2);
        chk("midrst_op_sel", 32'(bus.AluSel_311), 32'd10);
        wait_valid();
        pop_check("midrst");
        @(posedge clk);
        #1;

        // Gapped input stream
        send_op(4'd1, 4'd1, 4'd9, 1'b1);
        chk("gap_in1", 32'(bus.AluIn1_311), 32'd1);
        chk("gap_in2", 32'(bus.AluIn2_311), 32'd1);
        chk("gap_sel", 32'(bus.AluSel_311), 32'd9);
        wait_valid();
        pop_check("gap");
        @(posedge clk);
        #1;

        // Random operations across all opcodes
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a, b, s;
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = 4'(i);
            send_op(a, b, s, 1'b0);
            chk("rnd_sel_pass", 32'(bus.AluSel_311), 32'(s));
            wait_valid();
            pop_check("rnd");
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
